regfile_write_sched: RTL and testbench

//  Write-port scheduler for the Z80 register-pair file (register / split_reg

---
 rtl/regfile_write_sched.sv | 177 +++++++++++++++++
 tb/tb_regfile_write_sched.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_sched.sv
// ---------------------------------------------------------------------------
// regfile_write_sched
//
// Purpose:
//   Write-port scheduler for the Z80 register-pair file. Two requesters share
//   the single write port of the pair file:
//     A - ALU writeback, 16-bit data, byte or word modes
//     M - memory-load path, 8-bit data bus
//   Round-robin arbitration picks one requester per cycle. The scheduler then
//   drives the per-pair Load / H_Load / L_Load strobes and the shared write
//   data. A 16-bit M load is issued as two beats, low byte then high byte.
//   The two beats form a locked sequence, and A cannot cut in between them.
//
// Ports:
//   i_clk       clock; all state updates on the rising edge
//   i_rst_n     asynchronous active-low reset
//   i_a_req     ALU write request; held with idx/mode/data until o_a_gnt
//   i_a_idx     ALU target pair
//   i_a_mode    00 no-op, 01 low byte, 10 high byte, 11 full word
//   i_a_data    ALU write data; byte modes use the matching half
//   o_a_gnt     one-cycle pulse: ALU write issued this cycle
//   i_m_req     memory-load beat request; held until o_m_gnt
//   i_m_idx     memory-load target pair, latched on the first beat
//   i_m_word    1 = two-beat 16-bit load, 0 = single low-byte load
//   i_m_data    byte for the current beat
//   o_m_gnt     one-cycle pulse per accepted memory beat
//   o_m_done    one-cycle pulse with the final beat of a memory transfer
//   o_wr_data   write data broadcast to all pairs
//   o_load      one-hot full-word load strobe
//   o_h_load    one-hot high-byte load strobe
//   o_l_load    one-hot low-byte load strobe
//   o_busy      high while a two-beat memory load holds the port
//
// NPAIRS must not exceed 2**IDXW. An index at or above NPAIRS is still
// granted, but it raises no strobe, so the write is dropped.
// ---------------------------------------------------------------------------
module regfile_write_sched #(
    parameter int NPAIRS = 4,
    parameter int IDXW   = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_a_req,
    input  logic [IDXW-1:0]   i_a_idx,
    input  logic [1:0]        i_a_mode,
    input  logic [15:0]       i_a_data,
    output logic              o_a_gnt,
    input  logic              i_m_req,
    input  logic [IDXW-1:0]   i_m_idx,
    input  logic              i_m_word,
    input  logic [7:0]        i_m_data,
    output logic              o_m_gnt,
    output logic              o_m_done,
    output logic [15:0]       o_wr_data,
    output logic [NPAIRS-1:0] o_load,
    output logic [NPAIRS-1:0] o_h_load,
    output logic [NPAIRS-1:0] o_l_load,
    output logic              o_busy
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_M_LOCK = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_prio_m;
    logic [IDXW-1:0]   r_lock_idx;

    logic              w_a_elig;
    logic              w_m_elig;
    logic              w_grant_a;
    logic              w_grant_m;
    logic [NPAIRS-1:0] w_a_sel;
    logic [NPAIRS-1:0] w_m_sel;
    logic [NPAIRS-1:0] w_lk_sel;

    // A requester whose grant is showing this cycle has already been served.
    // Its request line is still high only because the handshake is one cycle
    // behind, so it sits out the next edge.
    assign w_a_elig  = i_a_req && !o_a_gnt;
    assign w_m_elig  = i_m_req && !o_m_gnt;
    assign w_grant_a = w_a_elig && (!w_m_elig || !r_prio_m);
    assign w_grant_m = w_m_elig && !w_grant_a;

    // One-hot pair decode. An index with no matching pair leaves the vector
    // at zero, so out-of-range writes are dropped without extra logic.
    always_comb begin
        w_a_sel  = '0;
        w_m_sel  = '0;
        w_lk_sel = '0;
        for (int p = 0; p < NPAIRS; p++) begin
            w_a_sel[p]  = (i_a_idx    == p[IDXW-1:0]);
            w_m_sel[p]  = (i_m_idx    == p[IDXW-1:0]);
            w_lk_sel[p] = (r_lock_idx == p[IDXW-1:0]);
        end
    end

    // Arbitration FSM with registered outputs. Strobes, grants and write data
    // default to zero every cycle, so each one is a single-cycle pulse.
    //
    // r_prio_m points at the requester that was not granted most recently.
    // A two-beat memory load updates it only on its closing beat, so the whole
    // locked pair counts as one grant.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_prio_m   <= 1'b0;
            r_lock_idx <= '0;
            o_a_gnt    <= 1'b0;
            o_m_gnt    <= 1'b0;
            o_m_done   <= 1'b0;
            o_wr_data  <= 16'h0000;
            o_load     <= '0;
            o_h_load   <= '0;
            o_l_load   <= '0;
            o_busy     <= 1'b0;
        end else begin
            o_a_gnt   <= 1'b0;
            o_m_gnt   <= 1'b0;
            o_m_done  <= 1'b0;
            o_wr_data <= 16'h0000;
            o_load    <= '0;
            o_h_load  <= '0;
            o_l_load  <= '0;

            case (r_state)
                ST_IDLE: begin
                    if (w_grant_a) begin
                        o_a_gnt   <= 1'b1;
                        o_wr_data <= i_a_data;
                        r_prio_m  <= 1'b1;
                        case (i_a_mode)
                            2'b11:   o_load   <= w_a_sel;
                            2'b01:   o_l_load <= w_a_sel;
                            2'b10:   o_h_load <= w_a_sel;
                            default: ;
                        endcase
                    end else if (w_grant_m) begin
                        o_m_gnt   <= 1'b1;
                        o_wr_data <= {i_m_data, i_m_data};
                        o_l_load  <= w_m_sel;
                        if (i_m_word) begin
                            r_lock_idx <= i_m_idx;
                            r_state    <= ST_M_LOCK;
                            o_busy     <= 1'b1;
                        end else begin
                            o_m_done <= 1'b1;
                            r_prio_m <= 1'b0;
                        end
                    end
                end

                // The high byte goes to the pair latched on the first beat.
                // The current idx/word inputs are ignored. The lock has no
                // timeout, so A waits for as long as the lock lasts.
                ST_M_LOCK: begin
                    if (w_m_elig) begin
                        o_m_gnt   <= 1'b1;
                        o_m_done  <= 1'b1;
                        o_wr_data <= {i_m_data, i_m_data};
                        o_h_load  <= w_lk_sel;
                        r_prio_m  <= 1'b0;
                        r_state   <= ST_IDLE;
                        o_busy    <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_sched.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_sched
//
// Directed bench for regfile_write_sched. Two DUT instances share the same
// stimulus: dut4 has NPAIRS=4 and dut3 has NPAIRS=3, so index 3 is out of
// range only on dut3. Each observation packs the control outputs and the
// write data into one vector in this order:
//   {a_gnt, m_gnt, m_done, busy, load[3:0], h_load[3:0], l_load[3:0], wr_data}
// ---------------------------------------------------------------------------
module tb_regfile_write_sched;

    logic        clk;
    logic        rst_n;
    logic        a_req;
    logic [1:0]  a_idx;
    logic [1:0]  a_mode;
    logic [15:0] a_data;
    logic        m_req;
    logic [1:0]  m_idx;
    logic        m_word;
    logic [7:0]  m_data;

    logic        a_gnt4, m_gnt4, m_done4, busy4;
    logic [15:0] wr_data4;
    logic [3:0]  load4, h_load4, l_load4;

    logic        a_gnt3, m_gnt3, m_done3, busy3;
    logic [15:0] wr_data3;
    logic [2:0]  load3, h_load3, l_load3;

    logic [31:0] obs4;
    logic [28:0] obs3;

    int checks;
    int passed;

    assign obs4 = {a_gnt4, m_gnt4, m_done4, busy4, load4, h_load4, l_load4, wr_data4};
    assign obs3 = {a_gnt3, m_gnt3, m_done3, busy3, load3, h_load3, l_load3, wr_data3};

    regfile_write_sched #(.NPAIRS(4), .IDXW(2)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_req(a_req), .i_a_idx(a_idx), .i_a_mode(a_mode), .i_a_data(a_data),
        .o_a_gnt(a_gnt4),
        .i_m_req(m_req), .i_m_idx(m_idx), .i_m_word(m_word), .i_m_data(m_data),
        .o_m_gnt(m_gnt4), .o_m_done(m_done4), .o_wr_data(wr_data4),
        .o_load(load4), .o_h_load(h_load4), .o_l_load(l_load4), .o_busy(busy4)
    );

    regfile_write_sched #(.NPAIRS(3), .IDXW(2)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_req(a_req), .i_a_idx(a_idx), .i_a_mode(a_mode), .i_a_data(a_data),
        .o_a_gnt(a_gnt3),
        .i_m_req(m_req), .i_m_idx(m_idx), .i_m_word(m_word), .i_m_data(m_data),
        .o_m_gnt(m_gnt3), .o_m_done(m_done3), .o_wr_data(wr_data3),
        .o_load(load3), .o_h_load(h_load3), .o_l_load(l_load3), .o_busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled 1 ns after the edge that produced them.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        a_req  = 1'b0; a_idx = 2'd0; a_mode = 2'b00; a_data = 16'h0000;
        m_req  = 1'b0; m_idx = 2'd0; m_word = 1'b0; m_data = 8'h00;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_n = 1'b0;
        #3;
        checks++;
        if (obs4 !== 32'h0) $display("[TB] FAIL reset_dut4 got %h want %h", obs4, 32'h0);
        else passed++;
        checks++;
        if (obs3 !== 29'h0) $display("[TB] FAIL reset_dut3 got %h want %h", obs3, 29'h0);
        else passed++;
        #9;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_word;
        a_req = 1'b1; a_idx = 2'd2; a_mode = 2'b11; a_data = 16'hBEEF;
        tick();
        checks++;
        if (obs4 !== {4'b1000, 4'b0100, 4'b0000, 4'b0000, 16'hBEEF})
            $display("[TB] FAIL full_word got %h want %h", obs4,
                     {4'b1000, 4'b0100, 4'b0000, 4'b0000, 16'hBEEF});
        else passed++;
        a_req = 1'b0;
        tick();
        checks++;
        if (obs4 !== 32'h0) $display("[TB] FAIL full_word_idle got %h want %h", obs4, 32'h0);
        else passed++;
    endtask

    task automatic test_m_word;
        m_req = 1'b1; m_word = 1'b1; m_idx = 2'd1; m_data = 8'h34;
        tick();
        checks++;
        if (obs4 !== {4'b0101, 4'b0000, 4'b0000, 4'b0010, 16'h3434})
            $display("[TB] FAIL m_beat1 got %h want %h", obs4,
                     {4'b0101, 4'b0000, 4'b0000, 4'b0010, 16'h3434});
        else passed++;
        // Change idx/word to show they are ignored on the closing beat.
        m_data = 8'h12; m_idx = 2'd3; m_word = 1'b0;
        tick();
        checks++;
        if (obs4 !== {4'b0001, 12'h000, 16'h0000})
            $display("[TB] FAIL m_gap got %h want %h", obs4, {4'b0001, 12'h000, 16'h0000});
        else passed++;
        tick();
        checks++;
        if (obs4 !== {4'b0110, 4'b0000, 4'b0010, 4'b0000, 16'h1212})
            $display("[TB] FAIL m_beat2 got %h want %h", obs4,
                     {4'b0110, 4'b0000, 4'b0010, 4'b0000, 16'h1212});
        else passed++;
        m_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        do_reset();
        a_req = 1'b1; a_idx = 2'd0; a_mode = 2'b11; a_data = 16'h1111;
        m_req = 1'b1; m_idx = 2'd2; m_word = 1'b0; m_data = 8'h55;
        tick();
        checks++;
        if (obs4 !== {4'b1000, 4'b0001, 8'h00, 16'h1111})
            $display("[TB] FAIL rr_first_a got %h want %h", obs4, {4'b1000, 4'b0001, 8'h00, 16'h1111});
        else passed++;
        tick();
        checks++;
        if (obs4 !== {4'b0110, 8'h00, 4'b0100, 16'h5555})
            $display("[TB] FAIL rr_then_m got %h want %h", obs4, {4'b0110, 8'h00, 4'b0100, 16'h5555});
        else passed++;
        tick();
        checks++;
        if (obs4 !== {4'b1000, 4'b0001, 8'h00, 16'h1111})
            $display("[TB] FAIL rr_again_a got %h want %h", obs4, {4'b1000, 4'b0001, 8'h00, 16'h1111});
        else passed++;
        tick();
        checks++;
        if (obs4 !== {4'b0110, 8'h00, 4'b0100, 16'h5555})
            $display("[TB] FAIL rr_again_m got %h want %h", obs4, {4'b0110, 8'h00, 4'b0100, 16'h5555});
        else passed++;
        idle_inputs();
        tick();
    endtask

    task automatic test_lock_blocks_a;
        int early_gnt;
        m_req = 1'b1; m_word = 1'b1; m_idx = 2'd3; m_data = 8'hAA;
        tick();
        checks++;
        if (obs4 !== {4'b0101, 8'h00, 4'b1000, 16'hAAAA})
            $display("[TB] FAIL lock_beat1 got %h want %h", obs4, {4'b0101, 8'h00, 4'b1000, 16'hAAAA});
        else passed++;
        m_req = 1'b0;
        a_req = 1'b1; a_idx = 2'd1; a_mode = 2'b11; a_data = 16'hCAFE;
        early_gnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (a_gnt4 !== 1'b0 || busy4 !== 1'b1) early_gnt++;
        end
        checks++;
        if (early_gnt !== 0) $display("[TB] FAIL lock_holds_a got %0d want %0d", early_gnt, 0);
        else passed++;
        m_req = 1'b1; m_data = 8'hBB;
        tick();
        checks++;
        if (obs4 !== {4'b0110, 4'b0000, 4'b1000, 4'b0000, 16'hBBBB})
            $display("[TB] FAIL lock_beat2 got %h want %h", obs4,
                     {4'b0110, 4'b0000, 4'b1000, 4'b0000, 16'hBBBB});
        else passed++;
        m_req = 1'b0;
        tick();
        checks++;
        if (obs4 !== {4'b1000, 4'b0010, 8'h00, 16'hCAFE})
            $display("[TB] FAIL lock_then_a got %h want %h", obs4, {4'b1000, 4'b0010, 8'h00, 16'hCAFE});
        else passed++;
        a_req = 1'b0;
        tick();
    endtask

    task automatic test_noop_range;
        a_req = 1'b1; a_idx = 2'd2; a_mode = 2'b00; a_data = 16'h1234;
        tick();
        checks++;
        if (obs4 !== {4'b1000, 12'h000, 16'h1234})
            $display("[TB] FAIL noop got %h want %h", obs4, {4'b1000, 12'h000, 16'h1234});
        else passed++;
        a_req = 1'b0;
        tick();
        a_req = 1'b1; a_idx = 2'd3; a_mode = 2'b11; a_data = 16'h9876;
        tick();
        checks++;
        if (obs3 !== {4'b1000, 9'h000, 16'h9876})
            $display("[TB] FAIL range_dut3 got %h want %h", obs3, {4'b1000, 9'h000, 16'h9876});
        else passed++;
        checks++;
        if (obs4 !== {4'b1000, 4'b1000, 8'h00, 16'h9876})
            $display("[TB] FAIL range_dut4 got %h want %h", obs4, {4'b1000, 4'b1000, 8'h00, 16'h9876});
        else passed++;
        a_req = 1'b0;
        tick();
        // Byte modes drive only the matching strobe.
        a_req = 1'b1; a_idx = 2'd0; a_mode = 2'b10; a_data = 16'h5A5A;
        tick();
        checks++;
        if (obs4 !== {4'b1000, 4'b0000, 4'b0001, 4'b0000, 16'h5A5A})
            $display("[TB] FAIL high_byte got %h want %h", obs4,
                     {4'b1000, 4'b0000, 4'b0001, 4'b0000, 16'h5A5A});
        else passed++;
        a_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_in_lock;
        m_req = 1'b1; m_word = 1'b1; m_idx = 2'd2; m_data = 8'h77;
        tick();
        checks++;
        if (obs4 !== {4'b0101, 8'h00, 4'b0100, 16'h7777})
            $display("[TB] FAIL rl_beat1 got %h want %h", obs4, {4'b0101, 8'h00, 4'b0100, 16'h7777});
        else passed++;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs4 !== 32'h0) $display("[TB] FAIL rl_reset got %h want %h", obs4, 32'h0);
        else passed++;
        #1;
        rst_n = 1'b1;
        m_idx = 2'd0; m_data = 8'h99; m_word = 1'b1;
        tick();
        checks++;
        if (obs4 !== {4'b0101, 8'h00, 4'b0001, 16'h9999})
            $display("[TB] FAIL rl_first_beat got %h want %h", obs4, {4'b0101, 8'h00, 4'b0001, 16'h9999});
        else passed++;
        m_req = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0;
        passed = 0;
        idle_inputs();
        test_reset();
        test_full_word();
        test_m_word();
        test_back_to_back();
        test_lock_blocks_a();
        test_noop_range();
        test_reset_in_lock();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
